// File: rtl/cpu_bus_pkg.sv
// Shared encodings for the register-bus controller: micro-op codes, FSM states and default widths.
package cpu_bus_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_REG_SEL_W  = 3;

    typedef enum logic [1:0] {
        OP_MOV  = 2'd0,
        OP_LDI  = 2'd1,
        OP_RD   = 2'd2,
        OP_ALUW = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_XFER  = 3'd1,
        ST_SETUP = 3'd2,
        ST_WB    = 3'd3,
        ST_TURN  = 3'd4
    } state_t;

    // First execution state entered when an op is accepted.
    function automatic state_t first_state(input op_t op);
        case (op)
            OP_LDI:  return ST_WB;
            OP_ALUW: return ST_SETUP;
            default: return ST_XFER;
        endcase
    endfunction

endpackage

// File: rtl/gp_register_bus_controller_if.sv
// Command, response and register-set control signals of the bus controller.
interface gp_register_bus_controller_if
    import cpu_bus_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int REG_SEL_W  = DEFAULT_REG_SEL_W
) ();

    logic                  cmd_valid;
    logic                  cmd_ready;
    op_t                   cmd_op;
    logic [REG_SEL_W-1:0]  cmd_dst;
    logic [REG_SEL_W-1:0]  cmd_src;
    logic [DATA_WIDTH-1:0] cmd_imm;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  reg_write;
    logic                  reg_read;
    logic [REG_SEL_W-1:0]  input_select;
    logic [REG_SEL_W-1:0]  output_select;
    logic [REG_SEL_W-1:0]  alu_output_select;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_data;

    modport master (
        input  cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_imm, alu_result,
        output cmd_ready, reg_write, reg_read, input_select, output_select,
               alu_output_select, rsp_valid, rsp_data
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_imm, alu_result,
        input  cmd_ready, reg_write, reg_read, input_select, output_select,
               alu_output_select, rsp_valid, rsp_data
    );

endinterface

// File: rtl/gp_register_bus_controller.sv
// Bus master for the 8x16 register set: one micro-op per handshake, single bus owner per cycle,
// and a fixed turnaround gap after every op before the next accept.
module gp_register_bus_controller
    import cpu_bus_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int REG_SEL_W  = DEFAULT_REG_SEL_W,
    parameter int TURNAROUND = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    gp_register_bus_controller_if.master bus,
    inout  wire  [DATA_WIDTH-1:0] data_bus
);

    localparam logic [1:0] TURN_LOAD = 2'(TURNAROUND - 1);

    state_t                state_q, next_state;
    op_t                   op_q, next_op;
    logic                  accept;
    logic [1:0]            turn_cnt_q;
    logic [DATA_WIDTH-1:0] imm_q;

    logic                  cmd_ready_q, reg_write_q, reg_read_q, drive_en_q, rsp_valid_q;
    logic                  reg_write_d, reg_read_d, drive_en_d, cmd_ready_d;
    logic [REG_SEL_W-1:0]  input_select_q, output_select_q, alu_output_select_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  rd_capture;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        next_state = state_q;
        next_op    = op_q;
        accept     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    accept     = 1'b1;
                    next_op    = bus.cmd_op;
                    next_state = first_state(bus.cmd_op);
                end
            end
            ST_XFER:  next_state = ST_TURN;
            ST_SETUP: next_state = ST_WB;
            ST_WB:    next_state = ST_TURN;
            ST_TURN:  if (turn_cnt_q == 2'd0) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase

        // Control outputs are decoded from the state being entered, then registered.
        reg_read_d  = (next_state == ST_XFER);
        reg_write_d = (next_state == ST_WB) || (next_state == ST_XFER && next_op == OP_MOV);
        drive_en_d  = (next_state == ST_WB);
        cmd_ready_d = (next_state == ST_IDLE);
    end

    assign rd_capture = (state_q == ST_XFER) && (op_q == OP_RD);

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q             <= ST_IDLE;
            op_q                <= OP_MOV;
            imm_q               <= '0;
            turn_cnt_q          <= '0;
            cmd_ready_q         <= 1'b0;
            reg_write_q         <= 1'b0;
            reg_read_q          <= 1'b0;
            drive_en_q          <= 1'b0;
            rsp_valid_q         <= 1'b0;
            rsp_data_q          <= '0;
            input_select_q      <= '0;
            output_select_q     <= '0;
            alu_output_select_q <= '0;
        end else begin
            state_q     <= next_state;
            op_q        <= next_op;
            cmd_ready_q <= cmd_ready_d;
            reg_write_q <= reg_write_d;
            reg_read_q  <= reg_read_d;
            drive_en_q  <= drive_en_d;
            rsp_valid_q <= rd_capture;

            if (rd_capture) rsp_data_q <= data_bus;

            if (accept) begin
                imm_q <= bus.cmd_imm;
                if (bus.cmd_op != OP_RD)
                    input_select_q <= bus.cmd_dst;
                if (bus.cmd_op == OP_MOV || bus.cmd_op == OP_RD)
                    output_select_q <= bus.cmd_src;
                // ALU operand select is only ever moved by ALUW and otherwise holds.
                if (bus.cmd_op == OP_ALUW)
                    alu_output_select_q <= bus.cmd_src;
            end

            if (next_state == ST_TURN && state_q != ST_TURN)
                turn_cnt_q <= TURN_LOAD;
            else if (state_q == ST_TURN && turn_cnt_q != 2'd0)
                turn_cnt_q <= turn_cnt_q - 2'd1;
        end
    end

    assign data_bus = drive_en_q ? ((op_q == OP_LDI) ? imm_q : bus.alu_result)
                                 : {DATA_WIDTH{1'bz}};

    assign bus.cmd_ready         = cmd_ready_q;
    assign bus.reg_write         = reg_write_q;
    assign bus.reg_read          = reg_read_q;
    assign bus.input_select      = input_select_q;
    assign bus.output_select     = output_select_q;
    assign bus.alu_output_select = alu_output_select_q;
    assign bus.rsp_valid         = rsp_valid_q;
    assign bus.rsp_data          = rsp_data_q;

endmodule

// File: tb/tb_gp_register_bus_controller.sv
// Bench for gp_register_bus_controller: behavioural 8x16 register set, ALU = A+1, and a
// scoreboard of expected RD responses checked by an independent monitor.
module tb_gp_register_bus_controller;
    import cpu_bus_pkg::*;

    localparam int DW = 16;
    localparam int SW = 3;
    localparam int TA = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    wire  [DW-1:0] data_bus;

    gp_register_bus_controller_if #(.DATA_WIDTH(DW), .REG_SEL_W(SW)) bus ();

    gp_register_bus_controller #(
        .DATA_WIDTH(DW), .REG_SEL_W(SW), .TURNAROUND(TA)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .data_bus (data_bus)
    );

    always #5 clock = ~clock;

    // Register set and ALU models.
    logic [DW-1:0] regs [8] = '{default: '0};
    always @(posedge clock) if (bus.reg_write) regs[bus.input_select] <= data_bus;
    assign data_bus       = bus.reg_read ? regs[bus.output_select] : {DW{1'bz}};
    assign bus.alu_result = regs[bus.alu_output_select] + 16'd1;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;
    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: bus-ownership invariant every cycle, response checking whenever rsp_valid is seen.
    logic prev_rsp = 1'b0;
    always @(negedge clock) begin
        exp_t e;
        check("bus_exclusive", {31'b0, dut.drive_en_q & bus.reg_read}, 32'd0);
        if (bus.rsp_valid) begin
            check("rsp_pulse_width", {31'b0, prev_rsp}, 32'd0);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected actual=%0h expected=none", bus.rsp_data);
            end else begin
                e = sb_q.pop_front();
                check("rsp_data", {16'b0, bus.rsp_data}, {16'b0, e.data});
                check("rsp_latency", cyc + 1, e.cyc);
            end
        end
        prev_rsp = bus.rsp_valid;
    end

    // Offers one op and leaves cmd_valid high; for RD, 'imm' is the expected response.
    task automatic issue(input op_t op, input logic [2:0] dst, input logic [2:0] src,
                         input logic [DW-1:0] imm, output int acc);
        int budget;
        @(negedge clock);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_dst   = dst;
        bus.cmd_src   = src;
        bus.cmd_imm   = imm;
        acc    = -1;
        budget = 0;
        while (!bus.cmd_ready && budget < 50) begin
            @(negedge clock);
            budget++;
        end
        if (!bus.cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=no_accept expected=accept op=%0d", op);
        end else begin
            acc = cyc + 1;
            @(posedge clock);
            if (op == OP_RD) sb_q.push_back('{imm, acc + 2});
        end
    endtask

    int a0, a1, a2, a3, a4, a5, a6, a7, a8, ax;

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_MOV;
        bus.cmd_dst   = '0;
        bus.cmd_src   = '0;
        bus.cmd_imm   = '0;

        repeat (2) @(negedge clock);
        check("rst_cmd_ready", {31'b0, bus.cmd_ready}, 32'd0);
        check("rst_reg_write", {31'b0, bus.reg_write}, 32'd0);
        check("rst_reg_read", {31'b0, bus.reg_read}, 32'd0);
        check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        check("rst_input_select", {29'b0, bus.input_select}, 32'd0);
        check("rst_output_select", {29'b0, bus.output_select}, 32'd0);
        check("rst_alu_select", {29'b0, bus.alu_output_select}, 32'd0);
        check("rst_rsp_data", {16'b0, bus.rsp_data}, 32'd0);
        check("rst_drive_en", {31'b0, dut.drive_en_q}, 32'd0);

        reset = 1'b0;
        #1 check("ready_before_first_edge", {31'b0, bus.cmd_ready}, 32'd0);
        @(negedge clock);
        check("ready_after_first_edge", {31'b0, bus.cmd_ready}, 32'd1);

        // Back-to-back stream with cmd_valid held high throughout.
        issue(OP_LDI, 3'd3, 3'd0, 16'hBEEF, a0);
        issue(OP_RD,  3'd0, 3'd3, 16'hBEEF, a1);
        check("spacing_ldi", a1 - a0, 1 + TA + 1);
        issue(OP_MOV, 3'd5, 3'd3, 16'h0000, a2);
        check("spacing_rd", a2 - a1, 1 + TA + 1);
        @(negedge clock);
        check("mov_read_write_same_cycle", {30'b0, bus.reg_read, bus.reg_write}, 32'd3);
        check("mov_output_select", {29'b0, bus.output_select}, 32'd3);
        check("mov_input_select", {29'b0, bus.input_select}, 32'd5);
        issue(OP_RD,  3'd0, 3'd5, 16'hBEEF, a3);
        check("spacing_mov", a3 - a2, 1 + TA + 1);
        issue(OP_RD,  3'd0, 3'd3, 16'hBEEF, a4);

        issue(OP_ALUW, 3'd1, 3'd3, 16'h0000, a5);
        check("spacing_rd2", a5 - a4, 1 + TA + 1);
        @(negedge clock);
        check("aluw_setup_select", {29'b0, bus.alu_output_select}, 32'd3);
        check("aluw_setup_quiet", {29'b0, bus.reg_write, bus.reg_read, dut.drive_en_q}, 32'd0);
        @(negedge clock);
        check("aluw_wb_write", {31'b0, bus.reg_write}, 32'd1);
        check("aluw_wb_input_select", {29'b0, bus.input_select}, 32'd1);
        check("aluw_wb_bus", {16'b0, data_bus}, 32'h0000_BEF0);
        issue(OP_RD,  3'd0, 3'd1, 16'hBEF0, a6);
        check("spacing_aluw", a6 - a5, 2 + TA + 1);

        // Fields changed while the controller is busy must not be taken until it is idle.
        issue(OP_LDI, 3'd6, 3'd0, 16'h1234, a7);
        check("spacing_rd3", a7 - a6, 1 + TA + 1);
        @(negedge clock);
        bus.cmd_dst = 3'd7;
        bus.cmd_imm = 16'hAAAA;
        check("busy_ready_wb", {31'b0, bus.cmd_ready}, 32'd0);
        @(negedge clock);
        bus.cmd_imm = 16'h5555;
        check("busy_ready_turn1", {31'b0, bus.cmd_ready}, 32'd0);
        @(negedge clock);
        bus.cmd_op = OP_RD;
        check("busy_ready_turn2", {31'b0, bus.cmd_ready}, 32'd0);
        issue(OP_LDI, 3'd7, 3'd0, 16'h7777, a8);
        check("spacing_ldi_busy", a8 - a7, 1 + TA + 1);
        issue(OP_RD,  3'd0, 3'd7, 16'h7777, ax);
        issue(OP_RD,  3'd0, 3'd6, 16'h1234, ax);
        issue(OP_RD,  3'd0, 3'd3, 16'hBEEF, ax);

        @(negedge clock);
        bus.cmd_valid = 1'b0;
        repeat (6) @(negedge clock);
        check("idle_no_activity", {30'b0, bus.reg_read, bus.reg_write}, 32'd0);
        check("idle_ready", {31'b0, bus.cmd_ready}, 32'd1);

        // Reset asserted in the middle of an ALUW write-back cycle.
        issue(OP_ALUW, 3'd2, 3'd1, 16'h0000, ax);
        @(negedge clock);
        @(negedge clock);
        check("pre_reset_wb_write", {31'b0, bus.reg_write}, 32'd1);
        bus.cmd_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("reset_kills_write", {31'b0, bus.reg_write}, 32'd0);
        check("reset_kills_drive", {31'b0, dut.drive_en_q}, 32'd0);
        check("reset_kills_ready", {31'b0, bus.cmd_ready}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        issue(OP_RD, 3'd0, 3'd2, 16'h0000, ax);
        issue(OP_RD, 3'd0, 3'd1, 16'hBEF0, ax);
        @(negedge clock);
        bus.cmd_valid = 1'b0;

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clock);
        check("scoreboard_drained", sb_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
